mem_sequencer: RTL and testbench

//  Parametrised load/store sequencer between the robin core and the 8-bit SoC memory.

---
 rtl/robin_pkg.sv | 40 ++++
 rtl/mem_seq_tagline.sv | 32 +++
 rtl/mem_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mem_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/robin_pkg.sv
// rtl/robin_pkg.sv - shared sizes, FSM states, tag type and load extension for the robin sequencer
package robin_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_W = 2'd1;
  localparam logic [1:0] SIZE_L = 2'd2;
  localparam logic [1:0] SIZE_Q = 2'd3;

  localparam int TAG_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RISSUE,
    ST_RDRAIN,
    ST_WSETUP,
    ST_WSTROBE,
    ST_ERR
  } seq_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [TAG_IDX_W-1:0] index;
  } tag_t;

  // raw holds the 2**size loaded bytes right-aligned, first byte most significant
  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                         input logic sgn);
    logic [63:0] r;
    case (size)
      SIZE_B:  r = {{56{sgn & raw[7]}}, raw[7:0]};
      SIZE_W:  r = {{48{sgn & raw[15]}}, raw[15:0]};
      SIZE_L:  r = {{32{sgn & raw[31]}}, raw[31:0]};
      SIZE_Q:  r = raw;
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_seq_tagline.sv
// rtl/mem_seq_tagline.sv - read-latency-deep delay line of {valid,last,index} byte tags
module mem_seq_tagline
  import robin_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic                 last_i,
  input  logic [TAG_IDX_W-1:0] index_i,
  output logic                 valid_o,
  output logic                 last_o,
  output logic [TAG_IDX_W-1:0] index_o
);

  tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{valid: valid_i, last: last_i, index: index_i};
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign valid_o = stage_q[DEPTH-1].valid;
  assign last_o  = stage_q[DEPTH-1].last;
  assign index_o = stage_q[DEPTH-1].index;

endmodule

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - splits big-endian core loads/stores into byte transfers on the 8-bit SoC memory
module mem_sequencer
  import robin_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int ALIGN_CHECK  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_data_out,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write
);

  seq_state_e            state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [TAG_IDX_W-1:0]  cnt_q, cnt_d, last_q, last_d;
  logic [63:0]           wsh_q, wsh_d, raw_q, raw_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [7:0]            wbyte_q, wbyte_d;
  logic                  mwrite_q, mwrite_d, rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  tag_in_valid, tag_in_last, tag_out_valid, tag_out_last;
  logic [TAG_IDX_W-1:0]  tag_in_idx, tag_out_idx, req_last;
  logic                  req_err;
  logic [63:0]           req_wext;
  logic [5:0]            byte_pos;

  assign req_last = TAG_IDX_W'((4'd1 << req_size) - 4'd1);
  assign req_err  = ((32'd8 << req_size) > 32'(DATA_WIDTH)) ||
                    ((ALIGN_CHECK != 0) && ((req_addr & ADDR_WIDTH'(req_last)) != '0));
  // store data left-aligned so byte k is always the top byte after k shifts
  assign req_wext = 64'(req_wdata) << (7'd64 - (7'd8 << req_size));
  assign byte_pos = {last_q - tag_out_idx, 3'b000};

  mem_seq_tagline #(.DEPTH(READ_LATENCY)) u_tagline (
    .clk     (clk),
    .reset   (reset),
    .valid_i (tag_in_valid),
    .last_i  (tag_in_last),
    .index_i (tag_in_idx),
    .valid_o (tag_out_valid),
    .last_o  (tag_out_last),
    .index_o (tag_out_idx)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    wsh_d        = wsh_q;
    raw_d        = raw_q;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    wbyte_d      = wbyte_q;
    mwrite_d     = 1'b0;
    rvalid_d     = 1'b0;
    rerr_d       = 1'b0;
    rdata_d      = rdata_q;
    tag_in_valid = 1'b0;
    tag_in_last  = 1'b0;
    tag_in_idx   = '0;

    if (tag_out_valid) begin
      raw_d[byte_pos +: 8] = mem_data_out;
      if (tag_out_last) begin
        rvalid_d = 1'b1;
        rdata_d  = DATA_WIDTH'(extend(raw_d, size_q, sgn_q));
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          sgn_d  = req_signed;
          last_d = req_last;
          if (req_err) begin
            state_d = ST_ERR;
          end else if (req_write) begin
            waddr_d = req_addr;
            wbyte_d = req_wext[63:56];
            wsh_d   = req_wext << 8;
            cnt_d   = '0;
            state_d = ST_WSETUP;
          end else begin
            raddr_d      = req_addr;
            tag_in_valid = 1'b1;
            tag_in_last  = (req_last == '0);
            cnt_d        = TAG_IDX_W'(1);
            state_d      = (req_last == '0) ? ST_RDRAIN : ST_RISSUE;
          end
        end
      end
      ST_RISSUE: begin
        raddr_d      = raddr_q + ADDR_WIDTH'(1);
        tag_in_valid = 1'b1;
        tag_in_idx   = cnt_q;
        tag_in_last  = (cnt_q == last_q);
        cnt_d        = cnt_q + TAG_IDX_W'(1);
        if (cnt_q == last_q) state_d = ST_RDRAIN;
      end
      ST_RDRAIN: begin
        if (tag_out_valid && tag_out_last) state_d = ST_IDLE;
      end
      ST_WSETUP: begin
        mwrite_d = 1'b1;
        state_d  = ST_WSTROBE;
      end
      ST_WSTROBE: begin
        if (cnt_q == last_q) begin
          rvalid_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          waddr_d = waddr_q + ADDR_WIDTH'(1);
          wbyte_d = wsh_q[63:56];
          wsh_d   = wsh_q << 8;
          cnt_d   = cnt_q + TAG_IDX_W'(1);
          state_d = ST_WSETUP;
        end
      end
      ST_ERR: begin
        rvalid_d = 1'b1;
        rerr_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      size_q   <= '0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
      wsh_q    <= '0;
      raw_q    <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wbyte_q  <= '0;
      mwrite_q <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      wsh_q    <= wsh_d;
      raw_q    <= raw_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wbyte_q  <= wbyte_d;
      mwrite_q <= mwrite_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE) && !reset;
  assign resp_valid  = rvalid_q;
  assign resp_err    = rerr_q;
  assign resp_rdata  = rdata_q;
  assign mem_raddr   = raddr_q;
  assign mem_waddr   = waddr_q;
  assign mem_data_in = wbyte_q;
  assign mem_write   = mwrite_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - scoreboard bench for mem_sequencer at read latencies 2, 1 and 3
module tb_mem_sequencer;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req_valid;
  logic            req_write, req_signed;
  logic [1:0]      req_size;
  logic [8:0]      req_addr;
  logic [31:0]     req_wdata;
  logic [2:0]      req_ready, resp_valid, resp_err, mem_write;
  logic [2:0][31:0] resp_rdata;
  logic [2:0][8:0] mem_raddr, mem_waddr;
  logic [2:0][7:0] mem_data_out, mem_data_in;
  logic [7:0]      mem [512];
  int              cyc = 0;
  int              n_tests = 0;
  int              n_fail = 0;

  typedef struct { int g; int cyc; logic err; logic [31:0] rdata; } resp_t;
  typedef struct { int g; int cyc; logic [8:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int g; int cyc; logic [8:0] addr; } ra_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];
  ra_t   ra_q[$];
  resp_t mr;
  wr_t   mw;
  logic [31:0] last_rd [3];
  logic [8:0]  exp_raddr [3];

  // instance 0: latency 2; instance 1: latency 1 with alignment check; instance 2: latency 3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    localparam int ALN = (g == 1) ? 1 : 0;
    localparam int PI  = (LAT >= 2) ? LAT - 2 : 0;
    logic [7:0] pipe [4];

    mem_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(LAT), .ALIGN_CHECK(ALN)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid[g]), .resp_err(resp_err[g]),
      .resp_rdata(resp_rdata[g]), .mem_raddr(mem_raddr[g]), .mem_data_out(mem_data_out[g]),
      .mem_waddr(mem_waddr[g]), .mem_data_in(mem_data_in[g]), .mem_write(mem_write[g])
    );

    always @(posedge clk) begin
      pipe[0] <= mem[mem_raddr[g]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data_out[g] = (LAT == 1) ? mem[mem_raddr[g]] : pipe[PI];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (resp_valid[g]) begin
        if (resp_q.size() == 0) check("unexpected_resp_valid", resp_valid[g], 0);
        else begin
          mr = resp_q.pop_front();
          check("resp_inst", g, mr.g);
          check("resp_cycle", cyc, mr.cyc);
          check("resp_err", resp_err[g], mr.err);
          check("resp_rdata", resp_rdata[g], mr.rdata);
        end
      end
      if (mem_write[g]) begin
        if (wr_q.size() == 0) check("unexpected_mem_write", mem_write[g], 0);
        else begin
          mw = wr_q.pop_front();
          check("wr_inst", g, mw.g);
          check("wr_cycle", cyc, mw.cyc);
          check("wr_addr", mem_waddr[g], mw.addr);
          check("wr_data", mem_data_in[g], mw.data);
        end
      end
    end
    if (ra_q.size() != 0 && ra_q[0].cyc == cyc) begin
      check("raddr", mem_raddr[ra_q[0].g], ra_q[0].addr);
      void'(ra_q.pop_front());
    end
  end

  task automatic issue(input int g, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [8:0] a, input logic [31:0] wd, output int e0);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid[g] = 1'b1;
    e0 = -1;
    for (int i = 0; i < 40 && e0 < 0; i++) begin
      if (req_ready[g]) begin
        @(posedge clk); #1;
        e0 = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    req_valid[g] = 1'b0;
    // scramble request fields after acceptance; the DUT must have captured them
    req_addr = 9'($urandom); req_size = 2'($urandom); req_write = ~wr; req_signed = ~sg;
    req_wdata = $urandom;
    if (e0 < 0) check("accept", req_ready[g], 1);
  endtask

  task automatic do_load(input int g, input logic [1:0] sz, input logic sg, input logic [8:0] a,
                         output int e0);
    int n;
    logic [63:0] v;
    issue(g, 1'b0, sz, sg, a, 32'h0, e0);
    if (e0 < 0) return;
    n = 1 << sz;
    if (sz == 2'd3 || (g == 1 && (a % n) != 0)) begin
      resp_q.push_back('{g, e0 + 1, 1'b1, last_rd[g]});
      return;
    end
    v = '0;
    for (int k = 0; k < n; k++) begin
      ra_q.push_back('{g, e0 + k, 9'(a + k)});
      v = (v << 8) | 64'(mem[9'(a + k)]);
    end
    if (sg && v[8*n-1]) v = v | (~64'h0 << (8*n));
    last_rd[g] = v[31:0];
    exp_raddr[g] = 9'(a + n - 1);
    resp_q.push_back('{g, e0 + n - 1 + lat_of(g), 1'b0, v[31:0]});
  endtask

  task automatic do_store(input int g, input logic [1:0] sz, input logic [8:0] a,
                          input logic [31:0] wd, input bit abort, output int e0);
    int n;
    issue(g, 1'b1, sz, 1'b0, a, wd, e0);
    if (e0 < 0) return;
    n = 1 << sz;
    if (sz == 2'd3 || (g == 1 && (a % n) != 0)) begin
      resp_q.push_back('{g, e0 + 1, 1'b1, last_rd[g]});
      return;
    end
    for (int k = 0; k < (abort ? 1 : n); k++)
      wr_q.push_back('{g, e0 + 2*k + 1, 9'(a + k), 8'(wd >> (8*(n-1-k)))});
    if (!abort) resp_q.push_back('{g, e0 + 2*n, 1'b0, last_rd[g]});
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (resp_q.size() + wr_q.size() + ra_q.size()) != 0; i++) begin
      @(posedge clk); #1;
    end
    if ((resp_q.size() + wr_q.size() + ra_q.size()) != 0) begin
      check("drain_pending", resp_q.size() + wr_q.size() + ra_q.size(), 0);
      resp_q.delete(); wr_q.delete(); ra_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int e0, e1;
    reset = 1'b1; req_valid = '0; req_write = 1'b0; req_signed = 1'b0;
    req_size = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
    mem[9'h10] = 8'hDE; mem[9'h11] = 8'hAD; mem[9'h12] = 8'hBE; mem[9'h13] = 8'hEF;
    mem[9'h20] = 8'h80; mem[9'h21] = 8'h01;
    for (int g = 0; g < 3; g++) begin last_rd[g] = '0; exp_raddr[g] = '0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_resp_valid", resp_valid, 3'b000);
    check("rst_resp_err", resp_err[0], 0);
    check("rst_rdata", resp_rdata[0], 0);
    check("rst_raddr", mem_raddr[0], 0);
    check("rst_waddr", mem_waddr[0], 0);
    check("rst_data_in", mem_data_in[0], 0);
    check("rst_mem_write", mem_write, 3'b000);
    reset = 1'b0;
    #1;
    check("ready_after_reset", req_ready, 3'b111);

    do_load(0, 2'd2, 1'b0, 9'h10, e0); drain();
    do_load(0, 2'd0, 1'b1, 9'h20, e0); drain();
    do_load(0, 2'd0, 1'b0, 9'h20, e0); drain();
    do_load(0, 2'd1, 1'b1, 9'h20, e0); drain();
    do_store(0, 2'd1, 9'h1FF, 32'h0000_1234, 1'b0, e0); drain();
    do_load(0, 2'd1, 1'b0, 9'h1FF, e0); drain();

    do_load(0, 2'd3, 1'b0, 9'h30, e0); drain();
    check("err_raddr_hold", mem_raddr[0], exp_raddr[0]);
    do_store(0, 2'd3, 9'h30, 32'h1, 1'b0, e0); drain();
    do_load(1, 2'd2, 1'b0, 9'h02, e0); drain();
    do_load(1, 2'd1, 1'b1, 9'h21, e0); drain();
    check("align_err_raddr_hold", mem_raddr[1], exp_raddr[1]);

    do_load(1, 2'd2, 1'b0, 9'h10, e0); drain();
    do_load(2, 2'd2, 1'b0, 9'h10, e0); drain();
    do_store(2, 2'd0, 9'h05, 32'hA5, 1'b0, e0); drain();

    do_store(0, 2'd2, 9'h40, 32'hCAFE_F00D, 1'b1, e0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_mem_write", mem_write[0], 0);
    check("abort_resp_valid", resp_valid[0], 0);
    reset = 1'b0;
    #1;
    check("abort_ready", req_ready[0], 1);
    for (int g = 0; g < 3; g++) begin last_rd[g] = '0; exp_raddr[g] = '0; end
    drain();

    do_load(0, 2'd2, 1'b0, 9'h10, e0);
    for (int i = 0; i < 20 && !resp_valid[0]; i++) begin @(posedge clk); #1; end
    check("b2b_ready", req_ready[0], 1);
    do_load(0, 2'd1, 1'b1, 9'h12, e1);
    check("b2b_accept_edge", e1, e0 + 6);
    drain();

    for (int i = 0; i < 12; i++) begin
      int g;
      g = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 0) do_load(g, 2'($urandom_range(0, 2)), 1'($urandom), 9'($urandom), e0);
      else do_store(g, 2'($urandom_range(0, 2)), 9'($urandom), $urandom, 1'b0, e0);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
